// File: rtl/add64_seq.sv
// Two-cycle 64-bit adder/subtractor: one 32-bit carry-lookahead adder reused
// for the low word, then the high word, with a registered inter-word carry.

module cla_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] s,
  output logic        g_out,
  output logic        p_out
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic        grp_c;
  logic        bit_c;
  logic        acc_g;
  logic        acc_p;

  always_comb begin
    g     = a & b;
    p     = a ^ b;
    gg    = '0;
    gp    = '0;
    c     = '0;
    grp_c = c_in;
    bit_c = 1'b0;
    acc_g = 1'b0;
    acc_p = 1'b1;

    // 4-bit group generate/propagate, independent of any carry-in
    for (int unsigned j = 0; j < 8; j++) begin
      for (int unsigned i = 0; i < 4; i++) begin
        gg[j] = g[4*j+i] | (p[4*j+i] & gg[j]);
      end
      gp[j] = &p[4*j +: 4];
    end

    // Group carries from the lookahead terms, then bit carries inside each group
    for (int unsigned j = 0; j < 8; j++) begin
      bit_c = grp_c;
      for (int unsigned i = 0; i < 4; i++) begin
        c[4*j+i] = bit_c;
        bit_c    = g[4*j+i] | (p[4*j+i] & bit_c);
      end
      grp_c = gg[j] | (gp[j] & grp_c);
      acc_g = gg[j] | (gp[j] & acc_g);
      acc_p = acc_p & gp[j];
    end

    s     = p ^ c;
    g_out = acc_g;
    p_out = acc_p;
  end

endmodule

module add64_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op_sub,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] sum,
  output logic        c_out,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] a_r;
  logic [63:0] bx_r;
  logic        sub_r;
  logic        k_r;
  logic        accept;

  logic [31:0] cla_a;
  logic [31:0] cla_b;
  logic [31:0] cla_s;
  logic        cla_cin;
  logic        cla_g;
  logic        cla_p;
  logic        cla_cout;

  cla_32 u_cla (
    .a     (cla_a),
    .b     (cla_b),
    .c_in  (cla_cin),
    .s     (cla_s),
    .g_out (cla_g),
    .p_out (cla_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = LO;
      end
      LO:   state_nxt = HI;
      HI:   state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    cla_a   = a_r[31:0];
    cla_b   = bx_r[31:0];
    cla_cin = sub_r;
    if (state == HI) begin
      cla_a   = a_r[63:32];
      cla_b   = bx_r[63:32];
      cla_cin = k_r;
    end
    cla_cout = cla_g | (cla_p & cla_cin);
  end

  // Operand B is stored already inverted for subtract; the +1 enters as c_in in LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      bx_r  <= '0;
      sub_r <= 1'b0;
      k_r   <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (accept) begin
        a_r   <= a;
        bx_r  <= op_sub ? ~b : b;
        sub_r <= op_sub;
      end
      if (state == LO) begin
        sum[31:0] <= cla_s;
        k_r       <= cla_cout;
      end
      if (state == HI) begin
        sum[63:32] <= cla_s;
        c_out      <= cla_cout;
        ovf        <= (a_r[63] == bx_r[63]) & (cla_s[31] != a_r[63]);
      end
    end
  end

endmodule

// File: tb/tb_add64_seq.sv
// Scoreboard bench for add64_seq: directed vectors push expected results,
// a negedge monitor pops and compares on each output handshake.

module tb_add64_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op_sub = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] sum;
  logic        c_out;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t q[$];

  add64_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got sum=0x%016h c=%0b o=%0b expected no output", sum, c_out, ovf);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (sum !== e.s || c_out !== e.c || ovf !== e.o) begin
          errors++;
          $display("FAIL result: got sum=0x%016h c=%0b o=%0b expected sum=0x%016h c=%0b o=%0b",
                   sum, c_out, ovf, e.s, e.c, e.o);
        end
      end
    end
  end

  task automatic push(input logic [63:0] s, input logic c, input logic o);
    exp_t e;
    e.s = s;
    e.c = c;
    e.o = o;
    q.push_back(e);
  endtask

  // Presents a bundle and returns #2 after the accepting edge
  task automatic issue(input logic [63:0] xa, input logic [63:0] xb, input logic xs);
    logic rdy;
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    a        = xa;
    b        = xb;
    op_sub   = xs;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    #2 in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    #2;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  initial begin
    #12;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum", sum, 64'd0);
    chk("rst_flags", {62'd0, c_out, ovf}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Word-boundary carry with latency and in_ready checks
    push(64'h00000001_00000000, 1'b0, 1'b0);
    issue(64'h00000000_FFFFFFFF, 64'h1, 1'b0);
    @(negedge clk);
    chk("lo_out_valid", {63'd0, out_valid}, 64'd0);
    chk("lo_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    chk("hi_out_valid", {63'd0, out_valid}, 64'd0);
    chk("hi_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    chk("done_out_valid", {63'd0, out_valid}, 64'd1);
    chk("done_in_ready", {63'd0, in_ready}, 64'd0);
    drain();

    push(64'h0, 1'b1, 1'b0);
    issue(64'hFFFFFFFF_FFFFFFFF, 64'h1, 1'b0);
    drain();
    push(64'h80000000_00000000, 1'b0, 1'b1);
    issue(64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0);
    drain();
    push(64'h7FFFFFFF_FFFFFFFF, 1'b1, 1'b1);
    issue(64'h80000000_00000000, 64'h1, 1'b1);
    drain();
    push(64'hFFFFFFFF_FFFFFFFE, 1'b0, 1'b0);
    issue(64'd5, 64'd7, 1'b1);
    drain();
    push(64'h22222222_22222211, 1'b0, 1'b0);
    issue(64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321, 1'b0);
    drain();

    // Backpressure: result held for 5 cycles while a new bundle waits
    out_ready = 1'b0;
    push(64'd2, 1'b1, 1'b0);
    issue(64'd7, 64'd5, 1'b1);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_sum", sum, 64'd2);
      chk("bp_flags", {62'd0, c_out, ovf}, 64'd2);
      if (i == 0) begin
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        a        = 64'd1;
        b        = 64'd1;
        op_sub   = 1'b0;
      end
    end
    @(posedge clk);
    #2 out_ready = 1'b1;
    push(64'd2, 1'b0, 1'b0);
    issue(64'd1, 64'd1, 1'b0);
    drain();

    // Reset during HI: outputs clear without a clock edge
    issue(64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", sum, 64'd0);
    chk("mid_rst_flags", {62'd0, c_out, ovf}, 64'd0);
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #2;
    push(64'd3, 1'b0, 1'b0);
    issue(64'd1, 64'd2, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
